// File: rtl/netdelay_pkg.sv
// Shared types and default sizing for the net-delay probe.
package netdelay_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/netdelay_probe.sv
// Active checker for an inverting net-delay path.
// Launches a word on drive, waits for its bitwise inverse on sense and reports
// the round-trip latency in clock cycles, or a timeout.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - measurement request, sampled only in IDLE
//   pattern   - launch word, captured when start is accepted
//   drive     - registered launch word toward the path under test
//   sense     - word returned from the path (expected ~drive)
//   busy      - high while a measurement is in flight (WAIT and DONE)
//   done      - one-cycle result-valid pulse
//   match_ok  - last measurement matched
//   timeout   - last measurement timed out
//   latency   - cycles from launch to match, or TIMEOUT on timeout
module netdelay_probe
  import netdelay_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] drive,
  input  logic [WIDTH-1:0] sense,
  output logic             busy,
  output logic             done,
  output logic             match_ok,
  output logic             timeout,
  output logic [CNT_W-1:0] latency
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sense_q;
  logic [WIDTH-1:0]   drive_d;
  logic               busy_d, done_d, match_d, timeout_d;
  logic [CNT_W-1:0]   latency_d;

  // State and output registers; sense is resampled every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sense_q  <= '0;
      drive    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      match_ok <= 1'b0;
      timeout  <= 1'b0;
      latency  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sense_q  <= sense;
      drive    <= drive_d;
      busy     <= busy_d;
      done     <= done_d;
      match_ok <= match_d;
      timeout  <= timeout_d;
      latency  <= latency_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drive_d   = drive;
    busy_d    = busy;
    done_d    = 1'b0;
    match_d   = match_ok;
    timeout_d = timeout;
    latency_d = latency;

    case (state_q)
      IDLE: begin
        if (start) begin
          drive_d   = pattern;
          cnt_d     = '0;
          match_d   = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = WAIT;
        end
      end

      WAIT: begin
        // cnt==0 only on the first WAIT cycle: skip the stale launch-edge sample.
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else if (sense_q == ~drive) begin
          latency_d = cnt_q;
          match_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          latency_d = CNT_W'(TIMEOUT);
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_netdelay_probe.sv
// Directed bench for netdelay_probe: table of measurements over several path
// models plus hand-written sequences for ignored starts and mid-run reset.
module tb_netdelay_probe;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pattern;
  logic [31:0] drive;
  logic [31:0] sense;
  logic        busy;
  logic        done;
  logic        match_ok;
  logic        timeout;
  logic [7:0]  latency;

  // Path models: 0 comb inverter, 1 three-flop inverter, 2 stuck at zero, 3 comb with fault mask.
  int          mode;
  logic [31:0] fault;
  logic [31:0] p1, p2, p3;

  int total;
  int bad;

  netdelay_probe #(.WIDTH(32), .CNT_W(8), .TIMEOUT(255)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .drive    (drive),
    .sense    (sense),
    .busy     (busy),
    .done     (done),
    .match_ok (match_ok),
    .timeout  (timeout),
    .latency  (latency)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    p1 <= ~drive;
    p2 <= p1;
    p3 <= p2;
  end

  always_comb begin
    case (mode)
      0:       sense = ~drive;
      1:       sense = p3;
      2:       sense = 32'h0000_0000;
      default: sense = ~drive ^ fault;
    endcase
  end

  typedef struct {
    int          mode;
    logic [31:0] fault;
    logic [31:0] pattern;
    logic [7:0]  exp_lat;
    logic        exp_match;
    logic        exp_to;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle, then count falling edges until done (bounded).
  // edges==1 at the first sample after the accept edge.
  task automatic run_meas(input logic [31:0] p, output int edges);
    @(negedge clk);
    start   = 1'b1;
    pattern = p;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    while (!done && edges < 400) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " drive"},    drive,           32'h0);
    chk({tag, " busy"},     32'(busy),       32'h0);
    chk({tag, " done"},     32'(done),       32'h0);
    chk({tag, " match_ok"}, 32'(match_ok),   32'h0);
    chk({tag, " timeout"},  32'(timeout),    32'h0);
    chk({tag, " latency"},  32'(latency),    32'h0);
  endtask

  initial begin
    int edges;
    int done_seen;

    total   = 0;
    bad     = 0;
    mode    = 0;
    fault   = 32'h0;
    rst     = 1'b1;
    start   = 1'b0;
    pattern = 32'h0;

    vecs[0] = '{0, 32'h0,         32'hA5A5_0F0F, 8'd1,   1'b1, 1'b0};
    vecs[1] = '{1, 32'h0,         32'h1234_5678, 8'd4,   1'b1, 1'b0};
    vecs[2] = '{2, 32'h0,         32'h0000_0000, 8'd255, 1'b0, 1'b1};
    vecs[3] = '{3, 32'h0000_0001, 32'h0F0F_1234, 8'd255, 1'b0, 1'b1};
    vecs[4] = '{3, 32'h8000_0000, 32'h0F0F_1234, 8'd255, 1'b0, 1'b1};
    vecs[5] = '{0, 32'h0,         32'hFFFF_FFFF, 8'd1,   1'b1, 1'b0};
    vecs[6] = '{1, 32'h0,         32'h0000_0001, 8'd4,   1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Table: done must first appear latency+2 samples after the accept edge.
    for (int i = 0; i < 7; i++) begin
      mode  = vecs[i].mode;
      fault = vecs[i].fault;
      run_meas(vecs[i].pattern, edges);
      chk($sformatf("v%0d done", i),     32'(done),     32'h1);
      chk($sformatf("v%0d edges", i),    32'(edges),    32'(vecs[i].exp_lat) + 32'd2);
      chk($sformatf("v%0d match", i),    32'(match_ok), 32'(vecs[i].exp_match));
      chk($sformatf("v%0d timeout", i),  32'(timeout),  32'(vecs[i].exp_to));
      chk($sformatf("v%0d latency", i),  32'(latency),  32'(vecs[i].exp_lat));
      chk($sformatf("v%0d drive", i),    drive,         vecs[i].pattern);
      chk($sformatf("v%0d busy", i),     32'(busy),     32'h1);
      @(negedge clk);
      chk($sformatf("v%0d done drop", i), 32'(done),    32'h0);
      chk($sformatf("v%0d busy drop", i), 32'(busy),    32'h0);
      chk($sformatf("v%0d hold lat", i),  32'(latency), 32'(vecs[i].exp_lat));
    end

    // Starts during WAIT and during DONE are ignored.
    mode = 1;
    @(negedge clk);
    start   = 1'b1;
    pattern = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    while (!done && edges < 400) begin
      @(negedge clk);
      edges++;
      if (edges == 3) begin
        start   = 1'b1;
        pattern = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
      end
    end
    chk("ign mid-wait drive", drive, 32'h1234_5678);
    chk("ign done",  32'(done),  32'h1);
    chk("ign edges", 32'(edges), 32'd6);
    start   = 1'b1;
    pattern = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    chk("ign drive",   drive,            32'h1234_5678);
    chk("ign latency", 32'(latency),     32'd4);
    chk("ign match",   32'(match_ok),    32'h1);
    chk("ign busy",    32'(busy),        32'h0);
    @(negedge clk);
    chk("ign still idle", 32'(busy),     32'h0);
    chk("ign drive2",     drive,         32'h1234_5678);

    // Reset in the middle of WAIT aborts with no done pulse.
    mode = 2;
    @(negedge clk);
    start   = 1'b1;
    pattern = 32'h0000_0055;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort busy before", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("abort quiet", 32'(done_seen), 32'h0);

    mode = 0;
    run_meas(32'h0BAD_F00D, edges);
    chk("post done",    32'(done),     32'h1);
    chk("post edges",   32'(edges),    32'd3);
    chk("post latency", 32'(latency),  32'd1);
    chk("post match",   32'(match_ok), 32'h1);
    chk("post timeout", 32'(timeout),  32'h0);
    chk("post drive",   drive,         32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
